// File: rtl/link_credit_rx.sv
// Narrow-to-wide link receiver: assembles sideband-framed beats into wide words,
// buffers them in a credit-managed FIFO and returns one credit per word popped.
module link_credit_rx #(
    parameter int unsigned HUB_FIFO_WIDTH          = 32,
    parameter int unsigned HUB_FIFO_PHYSICAL_WIDTH = 8,
    parameter int unsigned RX_DEPTH                = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [HUB_FIFO_PHYSICAL_WIDTH-1:0] narrow_fifo_data,
    input  logic                               narrow_fifo_valid,
    input  logic                               narrow_fifo_first,
    output logic                               credit_return,
    output logic [HUB_FIFO_WIDTH-1:0]          wide_fifo_data,
    output logic                               wide_fifo_valid,
    input  logic                               wide_fifo_ready,
    output logic [7:0]                         frame_error_count,
    output logic                               overflow_error
);

    localparam int unsigned W         = HUB_FIFO_WIDTH;
    localparam int unsigned P         = HUB_FIFO_PHYSICAL_WIDTH;
    localparam int unsigned NUM_BEATS = (W + P - 1) / P;
    localparam int unsigned ASM_W     = NUM_BEATS * P;
    localparam int unsigned BCW       = $clog2(NUM_BEATS + 1);
    localparam int unsigned PW        = $clog2(RX_DEPTH);
    localparam int unsigned CW        = PW + 1;

    // Assembly state
    logic [BCW-1:0]   beat_cnt;
    logic [BCW-1:0]   beat_cnt_nxt;
    logic [ASM_W-1:0] asm_q;
    logic [ASM_W-1:0] asm_nxt;
    logic [ASM_W-1:0] beat_ext;
    logic             push_c;
    logic             frame_err_c;
    logic [W-1:0]     push_word_c;

    // Buffer state
    logic [W-1:0]     mem [RX_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    occupancy;
    logic [CW-1:0]    occupancy_nxt;
    logic             pop_c;
    logic             full_c;
    logic             wr_en_c;
    logic             ovf_c;

    // Beat framing: beat 0 lands in the LSBs and is shifted up, so it ends as the MSB beat.
    always_comb begin
        beat_cnt_nxt = beat_cnt;
        asm_nxt      = asm_q;
        push_c       = 1'b0;
        frame_err_c  = 1'b0;
        beat_ext     = ASM_W'(narrow_fifo_data);
        if (narrow_fifo_valid) begin
            if (narrow_fifo_first) begin
                frame_err_c  = (beat_cnt != '0);
                asm_nxt      = beat_ext;
                beat_cnt_nxt = BCW'(1);
            end else if (beat_cnt != '0) begin
                asm_nxt      = (asm_q << P) | beat_ext;
                beat_cnt_nxt = beat_cnt + BCW'(1);
            end else begin
                frame_err_c  = 1'b1;
            end
            if (beat_cnt_nxt == BCW'(NUM_BEATS)) begin
                push_c       = 1'b1;
                beat_cnt_nxt = '0;
            end
        end
        push_word_c = asm_nxt[ASM_W-1 -: W];
    end

    // Buffer control: a full buffer still accepts a push when the head pops that cycle.
    always_comb begin
        pop_c         = wide_fifo_valid & wide_fifo_ready;
        full_c        = (occupancy == CW'(RX_DEPTH));
        wr_en_c       = push_c & (~full_c | pop_c);
        ovf_c         = push_c & full_c & ~pop_c;
        occupancy_nxt = occupancy;
        if (wr_en_c && !pop_c) begin
            occupancy_nxt = occupancy + CW'(1);
        end else if (!wr_en_c && pop_c) begin
            occupancy_nxt = occupancy - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt          <= '0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            occupancy         <= '0;
            credit_return     <= 1'b0;
            wide_fifo_valid   <= 1'b0;
            frame_error_count <= '0;
            overflow_error    <= 1'b0;
        end else begin
            beat_cnt        <= beat_cnt_nxt;
            occupancy       <= occupancy_nxt;
            wide_fifo_valid <= (occupancy_nxt != '0);
            credit_return   <= pop_c;
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (frame_err_c && frame_error_count != 8'hFF) begin
                frame_error_count <= frame_error_count + 8'd1;
            end
            if (ovf_c) begin
                overflow_error <= 1'b1;
            end
        end
    end

    // Datapath storage carries no reset; validity is tracked by pointers and occupancy.
    always_ff @(posedge clk) begin
        asm_q <= asm_nxt;
        if (wr_en_c && !reset) begin
            mem[wr_ptr] <= push_word_c;
        end
    end

    assign wide_fifo_data = mem[rd_ptr];

endmodule

// File: tb/tb_link_credit_rx.sv
// Directed bench for link_credit_rx: table-driven framing vectors plus hand-written
// overflow, full-buffer pop/push, reset and saturation sequences.
module tb_link_credit_rx;

    logic        clk;
    logic        reset;
    logic [7:0]  narrow_fifo_data;
    logic        narrow_fifo_valid;
    logic        narrow_fifo_first;
    logic        credit_return;
    logic [31:0] wide_fifo_data;
    logic        wide_fifo_valid;
    logic        wide_fifo_ready;
    logic [7:0]  frame_error_count;
    logic        overflow_error;

    int unsigned total_cnt;
    int unsigned pass_cnt;

    link_credit_rx #(
        .HUB_FIFO_WIDTH         (32),
        .HUB_FIFO_PHYSICAL_WIDTH(8),
        .RX_DEPTH               (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .narrow_fifo_data (narrow_fifo_data),
        .narrow_fifo_valid(narrow_fifo_valid),
        .narrow_fifo_first(narrow_fifo_first),
        .credit_return    (credit_return),
        .wide_fifo_data   (wide_fifo_data),
        .wide_fifo_valid  (wide_fifo_valid),
        .wide_fifo_ready  (wide_fifo_ready),
        .frame_error_count(frame_error_count),
        .overflow_error   (overflow_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        fst;
        logic [7:0]  dat;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_credit;
        logic [7:0]  e_ferr;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(input logic vld, input logic fst, input logic [7:0] dat,
                                input logic rdy, input logic e_valid, input logic [31:0] e_data,
                                input logic e_credit, input logic [7:0] e_ferr);
        vec_t v;
        v.vld = vld; v.fst = fst; v.dat = dat; v.rdy = rdy;
        v.e_valid = e_valid; v.e_data = e_data; v.e_credit = e_credit; v.e_ferr = e_ferr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic f);
        narrow_fifo_valid = 1'b1;
        narrow_fifo_first = f;
        narrow_fifo_data  = d;
        step();
        narrow_fifo_valid = 1'b0;
        narrow_fifo_first = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        beat(w[31:24], 1'b1);
        beat(w[23:16], 1'b0);
        beat(w[15:8],  1'b0);
        beat(w[7:0],   1'b0);
    endtask

    logic [31:0] words [5];

    initial begin
        total_cnt         = 0;
        pass_cnt          = 0;
        reset             = 1'b1;
        narrow_fifo_data  = 8'h5A;
        narrow_fifo_valid = 1'b1;
        narrow_fifo_first = 1'b0;
        wide_fifo_ready   = 1'b0;
        for (int i = 0; i < 5; i++) words[i] = 32'h1000_0001 * (i + 1) + 32'h0A0B_0C00;

        // Beats presented during reset must be ignored.
        step();
        step();
        reset             = 1'b0;
        narrow_fifo_valid = 1'b0;
        check("reset_valid",   32'(wide_fifo_valid),   32'd0);
        check("reset_credit",  32'(credit_return),     32'd0);
        check("reset_ferr",    32'(frame_error_count), 32'd0);
        check("reset_ovf",     32'(overflow_error),    32'd0);
        check("reset_occ",     32'(dut.occupancy),     32'd0);

        // Basic word, framing restart, and orphan-beat drop.
        tbl[0]  = mk(1, 1, 8'hDE, 1, 0, 32'h0,         0, 8'd0);
        tbl[1]  = mk(1, 0, 8'hAD, 1, 0, 32'h0,         0, 8'd0);
        tbl[2]  = mk(1, 0, 8'hBE, 1, 0, 32'h0,         0, 8'd0);
        tbl[3]  = mk(1, 0, 8'hEF, 1, 1, 32'hDEADBEEF,  0, 8'd0);
        tbl[4]  = mk(0, 0, 8'h00, 1, 0, 32'h0,         1, 8'd0);
        tbl[5]  = mk(0, 0, 8'h00, 1, 0, 32'h0,         0, 8'd0);
        tbl[6]  = mk(1, 1, 8'h11, 1, 0, 32'h0,         0, 8'd0);
        tbl[7]  = mk(1, 0, 8'h22, 1, 0, 32'h0,         0, 8'd0);
        tbl[8]  = mk(1, 1, 8'h33, 1, 0, 32'h0,         0, 8'd1);
        tbl[9]  = mk(1, 0, 8'h44, 1, 0, 32'h0,         0, 8'd1);
        tbl[10] = mk(1, 0, 8'h55, 1, 0, 32'h0,         0, 8'd1);
        tbl[11] = mk(1, 0, 8'h66, 1, 1, 32'h33445566,  0, 8'd1);
        tbl[12] = mk(0, 0, 8'h00, 1, 0, 32'h0,         1, 8'd1);
        tbl[13] = mk(0, 0, 8'h00, 1, 0, 32'h0,         0, 8'd1);
        tbl[14] = mk(1, 0, 8'h77, 1, 0, 32'h0,         0, 8'd2);
        tbl[15] = mk(0, 0, 8'h00, 1, 0, 32'h0,         0, 8'd2);

        for (int i = 0; i < 16; i++) begin
            narrow_fifo_valid = tbl[i].vld;
            narrow_fifo_first = tbl[i].fst;
            narrow_fifo_data  = tbl[i].dat;
            wide_fifo_ready   = tbl[i].rdy;
            step();
            check($sformatf("vec%0d_valid", i),  32'(wide_fifo_valid),   32'(tbl[i].e_valid));
            check($sformatf("vec%0d_credit", i), 32'(credit_return),     32'(tbl[i].e_credit));
            check($sformatf("vec%0d_ferr", i),   32'(frame_error_count), 32'(tbl[i].e_ferr));
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_data", i), wide_fifo_data, tbl[i].e_data);
            end
        end
        narrow_fifo_valid = 1'b0;
        check("tbl_ovf", 32'(overflow_error), 32'd0);

        // Overflow: four words fill the buffer, the fifth is dropped.
        wide_fifo_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(words[i]);
        check("ovf_occ4",   32'(dut.occupancy),  32'd4);
        check("ovf_pre",    32'(overflow_error), 32'd0);
        check("ovf_valid",  32'(wide_fifo_valid), 32'd1);
        send_word(words[4]);
        check("ovf_flag",   32'(overflow_error), 32'd1);
        check("ovf_occ",    32'(dut.occupancy),  32'd4);
        check("ovf_credit", 32'(credit_return),  32'd0);
        wide_fifo_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("ovf_pop%0d_data", i), wide_fifo_data, words[i]);
            step();
            check($sformatf("ovf_pop%0d_credit", i), 32'(credit_return), 32'd1);
        end
        wide_fifo_ready = 1'b0;
        step();
        check("ovf_drained_valid",  32'(wide_fifo_valid), 32'd0);
        check("ovf_drained_credit", 32'(credit_return),   32'd0);
        check("ovf_sticky",         32'(overflow_error),  32'd1);

        // Reset mid-word with beats presented during reset.
        beat(8'h99, 1'b1);
        beat(8'h88, 1'b0);
        reset             = 1'b1;
        narrow_fifo_valid = 1'b1;
        narrow_fifo_data  = 8'h42;
        step();
        step();
        reset             = 1'b0;
        narrow_fifo_valid = 1'b0;
        check("rst2_beat_cnt", 32'(dut.beat_cnt),     32'd0);
        check("rst2_occ",      32'(dut.occupancy),    32'd0);
        check("rst2_valid",    32'(wide_fifo_valid),  32'd0);
        check("rst2_credit",   32'(credit_return),    32'd0);
        check("rst2_ferr",     32'(frame_error_count), 32'd0);
        check("rst2_ovf",      32'(overflow_error),   32'd0);
        send_word(32'hCAFEF00D);
        check("rst2_word_valid", 32'(wide_fifo_valid),   32'd1);
        check("rst2_word_data",  wide_fifo_data,         32'hCAFEF00D);
        check("rst2_word_ferr",  32'(frame_error_count), 32'd0);
        wide_fifo_ready = 1'b1;
        step();
        wide_fifo_ready = 1'b0;
        check("rst2_pop_credit", 32'(credit_return), 32'd1);

        // Full buffer: pop and completing beat in the same cycle.
        for (int i = 0; i < 4; i++) send_word(words[i]);
        check("full_occ", 32'(dut.occupancy), 32'd4);
        beat(words[4][31:24], 1'b1);
        beat(words[4][23:16], 1'b0);
        beat(words[4][15:8],  1'b0);
        wide_fifo_ready = 1'b1;
        beat(words[4][7:0],   1'b0);
        wide_fifo_ready = 1'b0;
        check("full_pp_occ",    32'(dut.occupancy), 32'd4);
        check("full_pp_ovf",    32'(overflow_error), 32'd0);
        check("full_pp_credit", 32'(credit_return),  32'd1);
        step();
        check("full_pp_single_credit", 32'(credit_return), 32'd0);
        check("full_pp_occ_hold",      32'(dut.occupancy), 32'd4);
        wide_fifo_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check($sformatf("full_pop%0d_data", i), wide_fifo_data, words[i]);
            step();
        end
        wide_fifo_ready = 1'b0;
        step();
        check("full_drained_valid", 32'(wide_fifo_valid), 32'd0);

        // Framing error count saturates at 255.
        for (int i = 0; i < 254; i++) beat(8'h01, 1'b0);
        check("sat_254", 32'(frame_error_count), 32'd254);
        for (int i = 0; i < 4; i++) beat(8'h01, 1'b0);
        check("sat_255", 32'(frame_error_count), 32'd255);
        check("sat_no_word", 32'(wide_fifo_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
